// File: rtl/ehl_ahb_matrix_out.sv
// ---------------------------------------------------------------------------
// ehl_ahb_matrix_out
//   AHB matrix output stage, one instance per slave port. Arbitrates among
//   MNUM masters whose routed htrans targets this slave. It drives the grant
//   owner's address, control and write data onto the slave. Masters that lose
//   arbitration have their address phase captured in per-master pending
//   registers and are stalled until those requests are served.
//
// Parameters
//   MNUM          number of master ports (1..16)
//
// Build option
//   EHL_AHB_MATRIX_OUT_RR_EN  defined   : round-robin arbitration
//                             undefined : fixed priority, master 0 highest
//
// Ports
//   hclk, hresetn     clock (rising edge), asynchronous active-low reset
//   im_haddr          MNUM x 32  per-master address
//   im_htrans         MNUM x 2   per-master htrans (already masked upstream)
//   im_hctl           MNUM x 11  per-master {hwrite,hprot,hburst,hsize}
//   im_hwdata         MNUM x 32  per-master write data
//   im_hready         MNUM       HREADY seen on each master bus
//   om_hready         MNUM       per-master ready back to the input stages
//   om_hresp          MNUM x 2   per-master response
//   om_hrdata         32         broadcast read data
//   os_hsel/haddr/htrans/hctl/hwdata/hready   slave-side drive
//   is_hreadyout/is_hresp/is_hrdata           slave-side response
// ---------------------------------------------------------------------------
module ehl_ahb_matrix_out #(
    parameter int MNUM = 4
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [MNUM*32-1:0] im_haddr,
    input  logic [MNUM*2-1:0]  im_htrans,
    input  logic [MNUM*11-1:0] im_hctl,
    input  logic [MNUM*32-1:0] im_hwdata,
    input  logic [MNUM-1:0]    im_hready,
    output logic [MNUM-1:0]    om_hready,
    output logic [MNUM*2-1:0]  om_hresp,
    output logic [31:0]        om_hrdata,
    output logic               os_hsel,
    output logic [31:0]        os_haddr,
    output logic [1:0]         os_htrans,
    output logic [10:0]        os_hctl,
    output logic [31:0]        os_hwdata,
    output logic               os_hready,
    input  logic               is_hreadyout,
    input  logic [1:0]         is_hresp,
    input  logic [31:0]        is_hrdata
);

    localparam int IW = (MNUM > 1) ? $clog2(MNUM) : 1;

    localparam logic [1:0] HT_IDLE = 2'b00;
    localparam logic [1:0] HT_BUSY = 2'b01;
    localparam logic [1:0] HT_NSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ  = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // First requester found when scanning upward from 'start', wrapping at
    // MNUM. Result is {valid, index}.
    function automatic logic [IW:0] arb_pick(input logic [MNUM-1:0] r,
                                             input logic [IW-1:0]   start);
        logic [IW:0]   res;
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        res = '0;
        for (int i = MNUM - 1; i >= 0; i--) begin
            sum = {1'b0, start} + (IW+1)'(i);
            if (sum >= (IW+1)'(MNUM)) sum = sum - (IW+1)'(MNUM);
            idx = sum[IW-1:0];
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Per-master views of the packed input buses
    logic [31:0] m_addr  [MNUM];
    logic [1:0]  m_trans [MNUM];
    logic [10:0] m_ctl   [MNUM];
    logic [31:0] m_wdata [MNUM];

    always_comb begin
        for (int m = 0; m < MNUM; m++) begin
            m_addr[m]  = im_haddr[m*32 +: 32];
            m_trans[m] = im_htrans[m*2 +: 2];
            m_ctl[m]   = im_hctl[m*11 +: 11];
            m_wdata[m] = im_hwdata[m*32 +: 32];
        end
    end

    // Control state
    logic [MNUM-1:0] pend_vld_q, pend_vld_d;
    logic            dp_vld_q,   dp_vld_d;
    logic [IW-1:0]   dp_owner_q, dp_owner_d;
    logic [IW-1:0]   owner_q,    owner_d;
    logic [31:0]     last_addr_q, last_addr_d;
    logic [10:0]     last_ctl_q,  last_ctl_d;

    // Captured address phases (data only, no reset)
    logic [31:0] pend_addr_q [MNUM];
    logic [10:0] pend_ctl_q  [MNUM];

    logic [MNUM-1:0] live;
    logic [MNUM-1:0] req;
    logic [MNUM-1:0] acc_vec;
    logic [IW-1:0]   arb_start;
    logic [IW:0]     pick;
    logic            lock;
    logic            gvld;
    logic [IW-1:0]   grant;
    logic            accept;
    logic            src_pend;
    logic [31:0]     src_addr;
    logic [10:0]     src_ctl;
    logic [1:0]      src_trans;

`ifdef EHL_AHB_MATRIX_OUT_RR_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (grant == IW'(MNUM - 1)) rr_ptr_d = '0;
            else                        rr_ptr_d = grant + IW'(1);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) rr_ptr_q <= '0;
        else          rr_ptr_q <= rr_ptr_d;
    end

    assign arb_start = rr_ptr_q;
`else
    assign arb_start = '0;
`endif

    // ---- request / arbitration (address phase, combinational) ----
    always_comb begin
        // A pending master is stalled, so its bus copy is never a new request.
        for (int m = 0; m < MNUM; m++)
            live[m] = m_trans[m][1] & im_hready[m] & ~pend_vld_q[m];
        req  = pend_vld_q | live;
        // The owner keeps the slave for the remaining beats of its burst.
        lock = (m_trans[owner_q] == HT_SEQ) || (m_trans[owner_q] == HT_BUSY);
        pick = arb_pick(req, arb_start);
        if (lock) begin
            gvld  = 1'b1;
            grant = owner_q;
        end else begin
            gvld  = pick[IW];
            grant = pick[IW-1:0];
        end
        accept = gvld & is_hreadyout;
        for (int m = 0; m < MNUM; m++)
            acc_vec[m] = accept && (grant == IW'(m));
    end

    // ---- slave drive ----
    always_comb begin
        src_pend  = pend_vld_q[grant];
        src_addr  = src_pend ? pend_addr_q[grant] : m_addr[grant];
        src_ctl   = src_pend ? pend_ctl_q[grant]  : m_ctl[grant];
        src_trans = src_pend ? HT_NSEQ            : m_trans[grant];
        // A SEQ beat from a master that did not own the previous address
        // phase starts a new transfer as far as this slave is concerned.
        if ((grant != owner_q) && (src_trans == HT_SEQ)) src_trans = HT_NSEQ;

        if (gvld) begin
            os_hsel   = 1'b1;
            os_htrans = src_trans;
            os_haddr  = src_addr;
            os_hctl   = src_ctl;
        end else begin
            os_hsel   = 1'b0;
            os_htrans = HT_IDLE;
            os_haddr  = last_addr_q;
            os_hctl   = last_ctl_q;
        end
    end

    assign os_hwdata = m_wdata[dp_owner_q];
    assign os_hready = is_hreadyout;
    assign om_hrdata = is_hrdata;

    // ---- per-master response ----
    always_comb begin
        om_hready = '1;
        om_hresp  = '0;
        for (int m = 0; m < MNUM; m++) begin
            if (dp_vld_q && (dp_owner_q == IW'(m))) begin
                om_hready[m]       = is_hreadyout;
                om_hresp[m*2 +: 2] = is_hresp;
            end else begin
                om_hresp[m*2 +: 2] = RESP_OKAY;
                if (pend_vld_q[m] || (live[m] && !acc_vec[m]))
                    om_hready[m] = 1'b0;
            end
        end
    end

    // ---- next state ----
    always_comb begin
        pend_vld_d  = (pend_vld_q | live) & ~acc_vec;
        dp_vld_d    = dp_vld_q;
        dp_owner_d  = dp_owner_q;
        owner_d     = owner_q;
        last_addr_d = last_addr_q;
        last_ctl_d  = last_ctl_q;
        if (is_hreadyout) dp_vld_d = accept;
        if (accept) begin
            dp_owner_d  = grant;
            owner_d     = grant;
            last_addr_d = src_addr;
            last_ctl_d  = src_ctl;
        end
    end

    // ---- address phase -> data phase register boundary ----
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pend_vld_q  <= '0;
            dp_vld_q    <= 1'b0;
            dp_owner_q  <= '0;
            owner_q     <= '0;
            last_addr_q <= '0;
            last_ctl_q  <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            dp_vld_q    <= dp_vld_d;
            dp_owner_q  <= dp_owner_d;
            owner_q     <= owner_d;
            last_addr_q <= last_addr_d;
            last_ctl_q  <= last_ctl_d;
        end
    end

    always_ff @(posedge hclk) begin
        for (int m = 0; m < MNUM; m++) begin
            if (live[m] && !acc_vec[m]) begin
                pend_addr_q[m] <= m_addr[m];
                pend_ctl_q[m]  <= m_ctl[m];
            end
        end
    end

endmodule

// File: tb/tb_ehl_ahb_matrix_out.sv
// ---------------------------------------------------------------------------
// tb_ehl_ahb_matrix_out
//   Directed bench for ehl_ahb_matrix_out with MNUM=4. A table of per-cycle
//   vectors walks through single transfers, contention, burst lock, slave wait
//   states and ERROR responses; hand-written sequences then cover reset values,
//   asynchronous reset with pending requests, and the arbitration order.
//   Stimulus conventions: master m address = (m<<16) | a, control = 0x040|m,
//   write data = 0xDA7A0000|m, slave read data = 0x5EED0000 + vector index.
//   The vector table describes the default (fixed-priority) build.
// ---------------------------------------------------------------------------
module tb_ehl_ahb_matrix_out;

    localparam int MNUM = 4;
    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] S = 2'b11;

    logic               hclk = 1'b0;
    logic               hresetn;
    logic [MNUM*32-1:0] im_haddr;
    logic [MNUM*2-1:0]  im_htrans;
    logic [MNUM*11-1:0] im_hctl;
    logic [MNUM*32-1:0] im_hwdata;
    logic [MNUM-1:0]    im_hready;
    logic [MNUM-1:0]    om_hready;
    logic [MNUM*2-1:0]  om_hresp;
    logic [31:0]        om_hrdata;
    logic               os_hsel;
    logic [31:0]        os_haddr;
    logic [1:0]         os_htrans;
    logic [10:0]        os_hctl;
    logic [31:0]        os_hwdata;
    logic               os_hready;
    logic               is_hreadyout;
    logic [1:0]         is_hresp;
    logic [31:0]        is_hrdata;

    always #5 hclk = ~hclk;

    ehl_ahb_matrix_out #(.MNUM(MNUM)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .im_haddr(im_haddr), .im_htrans(im_htrans), .im_hctl(im_hctl),
        .im_hwdata(im_hwdata), .im_hready(im_hready),
        .om_hready(om_hready), .om_hresp(om_hresp), .om_hrdata(om_hrdata),
        .os_hsel(os_hsel), .os_haddr(os_haddr), .os_htrans(os_htrans),
        .os_hctl(os_hctl), .os_hwdata(os_hwdata), .os_hready(os_hready),
        .is_hreadyout(is_hreadyout), .is_hresp(is_hresp), .is_hrdata(is_hrdata)
    );

    typedef struct {
        logic [7:0]  tr;
        logic [3:0]  mr;
        logic [11:0] a;
        logic        sr;
        logic [1:0]  rs;
        logic        e_hsel;
        logic [1:0]  e_htrans;
        logic [31:0] e_haddr;
        logic [10:0] e_hctl;
        logic [1:0]  e_wm;
        logic [3:0]  e_hready;
        logic [7:0]  e_hresp;
    } vec_t;

    vec_t vt [22];
    int   n_tot = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [7:0] tr, input logic [3:0] mr,
                                input logic [11:0] a, input logic sr,
                                input logic [1:0] rs, input logic e_hsel,
                                input logic [1:0] e_htrans, input logic [31:0] e_haddr,
                                input logic [10:0] e_hctl, input logic [1:0] e_wm,
                                input logic [3:0] e_hready, input logic [7:0] e_hresp);
        vec_t v;
        v.tr = tr; v.mr = mr; v.a = a; v.sr = sr; v.rs = rs;
        v.e_hsel = e_hsel; v.e_htrans = e_htrans; v.e_haddr = e_haddr;
        v.e_hctl = e_hctl; v.e_wm = e_wm; v.e_hready = e_hready; v.e_hresp = e_hresp;
        return v;
    endfunction

    task automatic drive(input logic [7:0] tr, input logic [3:0] mr,
                         input logic [11:0] a, input logic sr,
                         input logic [1:0] rs, input logic [31:0] rd);
        for (int m = 0; m < MNUM; m++) begin
            im_htrans[m*2 +: 2]  = tr[m*2 +: 2];
            im_haddr[m*32 +: 32] = (32'(m) << 16) | {20'h0, a};
        end
        im_hready    = mr;
        is_hreadyout = sr;
        is_hresp     = rs;
        is_hrdata    = rd;
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_a;

        for (int m = 0; m < MNUM; m++) begin
            im_hctl[m*11 +: 11]   = 11'h040 | 11'(m);
            im_hwdata[m*32 +: 32] = 32'hDA7A_0000 | 32'(m);
        end

        //            tr            mr    a      sr rs   hsel htr addr          ctl     wm hrdy  hresp
        vt[0]  = mk({I,I,I,N}, 4'hF, 12'h100, 1, 0,  1, N, 32'h0000_0100, 11'h040, 0, 4'hF, 8'h00);
        vt[1]  = mk({I,I,I,I}, 4'hF, 12'h000, 1, 0,  0, I, 32'h0000_0100, 11'h040, 0, 4'hF, 8'h00);
        vt[2]  = mk({I,I,N,N}, 4'hF, 12'h200, 1, 0,  1, N, 32'h0000_0200, 11'h040, 0, 4'hD, 8'h00);
        vt[3]  = mk({I,I,N,I}, 4'hD, 12'h300, 1, 0,  1, N, 32'h0001_0200, 11'h041, 0, 4'hD, 8'h00);
        vt[4]  = mk({I,I,I,I}, 4'hF, 12'h000, 1, 0,  0, I, 32'h0001_0200, 11'h041, 1, 4'hF, 8'h00);
        vt[5]  = mk({I,I,I,N}, 4'hF, 12'h400, 1, 0,  1, N, 32'h0000_0400, 11'h040, 1, 4'hF, 8'h00);
        vt[6]  = mk({I,N,I,S}, 4'hF, 12'h404, 1, 0,  1, S, 32'h0000_0404, 11'h040, 0, 4'hB, 8'h00);
        vt[7]  = mk({I,N,I,S}, 4'hB, 12'h408, 1, 0,  1, S, 32'h0000_0408, 11'h040, 0, 4'hB, 8'h00);
        vt[8]  = mk({I,N,I,S}, 4'hB, 12'h40C, 1, 0,  1, S, 32'h0000_040C, 11'h040, 0, 4'hB, 8'h00);
        vt[9]  = mk({N,N,I,I}, 4'hB, 12'h410, 1, 0,  1, N, 32'h0002_0404, 11'h042, 0, 4'h3, 8'h00);
        vt[10] = mk({N,I,I,I}, 4'h7, 12'h414, 1, 0,  1, N, 32'h0003_0410, 11'h043, 2, 4'h7, 8'h00);
        vt[11] = mk({I,I,I,I}, 4'hF, 12'h000, 1, 0,  0, I, 32'h0003_0410, 11'h043, 3, 4'hF, 8'h00);
        vt[12] = mk({I,I,S,I}, 4'hF, 12'h500, 1, 0,  1, N, 32'h0001_0500, 11'h041, 3, 4'hF, 8'h00);
        vt[13] = mk({I,B,I,I}, 4'hF, 12'h000, 1, 0,  0, I, 32'h0001_0500, 11'h041, 1, 4'hF, 8'h00);
        vt[14] = mk({I,I,N,I}, 4'hF, 12'h600, 1, 0,  1, N, 32'h0001_0600, 11'h041, 1, 4'hF, 8'h00);
        vt[15] = mk({I,I,I,I}, 4'hD, 12'h000, 0, 0,  0, I, 32'h0001_0600, 11'h041, 1, 4'hD, 8'h00);
        vt[16] = mk({I,I,I,N}, 4'hD, 12'h610, 0, 0,  1, N, 32'h0000_0610, 11'h040, 1, 4'hC, 8'h00);
        vt[17] = mk({I,I,I,N}, 4'hC, 12'h620, 0, 0,  1, N, 32'h0000_0610, 11'h040, 1, 4'hC, 8'h00);
        vt[18] = mk({I,I,I,N}, 4'hC, 12'h630, 1, 0,  1, N, 32'h0000_0610, 11'h040, 1, 4'hE, 8'h00);
        vt[19] = mk({I,I,I,I}, 4'hE, 12'h000, 0, 1,  0, I, 32'h0000_0610, 11'h040, 0, 4'hE, 8'h01);
        vt[20] = mk({I,I,I,I}, 4'hE, 12'h000, 1, 1,  0, I, 32'h0000_0610, 11'h040, 0, 4'hF, 8'h01);
        vt[21] = mk({I,I,I,I}, 4'hF, 12'h000, 1, 1,  0, I, 32'h0000_0610, 11'h040, 0, 4'hF, 8'h00);

        // Reset values
        hresetn = 1'b0;
        drive({I,I,I,I}, 4'hF, 12'h000, 1'b1, 2'b00, 32'h0);
        #12;
        chk("rst_hsel",   0, 32'(os_hsel),   32'h0);
        chk("rst_htrans", 0, 32'(os_htrans), 32'h0);
        chk("rst_haddr",  0, os_haddr,       32'h0);
        chk("rst_hctl",   0, 32'(os_hctl),   32'h0);
        chk("rst_hready", 0, 32'(om_hready), 32'hF);
        chk("rst_hresp",  0, 32'(om_hresp),  32'h0);
        @(negedge hclk);
        hresetn = 1'b1;

        // Table: one vector per clock, checked mid-cycle before the next edge
        for (int i = 0; i < 22; i++) begin
            @(posedge hclk);
            #1;
            drive(vt[i].tr, vt[i].mr, vt[i].a, vt[i].sr, vt[i].rs,
                  32'h5EED_0000 + 32'(i));
            #2;
            chk("hsel",   i, 32'(os_hsel),   32'(vt[i].e_hsel));
            chk("htrans", i, 32'(os_htrans), 32'(vt[i].e_htrans));
            chk("haddr",  i, os_haddr,       vt[i].e_haddr);
            chk("hctl",   i, 32'(os_hctl),   32'(vt[i].e_hctl));
            chk("hwdata", i, os_hwdata,      32'hDA7A_0000 | 32'(vt[i].e_wm));
            chk("hready", i, 32'(om_hready), 32'(vt[i].e_hready));
            chk("hresp",  i, 32'(om_hresp),  32'(vt[i].e_hresp));
            chk("hrdata", i, om_hrdata,      32'h5EED_0000 + 32'(i));
            chk("os_hready", i, 32'(os_hready), 32'(vt[i].sr));
        end

        // Asynchronous reset drops a pending request
        @(posedge hclk); #1;
        drive({I,I,N,N}, 4'hF, 12'h700, 1'b1, 2'b00, 32'h0);
        @(posedge hclk); #1;
        drive({I,I,N,I}, 4'hD, 12'h700, 1'b1, 2'b00, 32'h0);
        #1;
        chk("pend_before_rst", 100, 32'(om_hready), 32'hD);
        chk("pend_before_rst_hsel", 100, 32'(os_hsel), 32'h1);
        #1;
        hresetn = 1'b0;
        #1;
        chk("rst_mid_hready", 101, 32'(om_hready), 32'hF);
        chk("rst_mid_hsel",   101, 32'(os_hsel),   32'h0);
        chk("rst_mid_haddr",  101, os_haddr,       32'h0);
        chk("rst_mid_hctl",   101, 32'(os_hctl),   32'h0);
        @(negedge hclk);
        hresetn = 1'b1;
        drive({I,I,I,I}, 4'hF, 12'h000, 1'b1, 2'b00, 32'h0);

        // Arbitration order: M0 alone, then M0 and M1 together
        @(posedge hclk); #1;
        drive({I,I,I,N}, 4'hF, 12'h800, 1'b1, 2'b00, 32'h0);
        #1;
        chk("arb_first", 102, os_haddr, 32'h0000_0800);
        @(posedge hclk); #1;
        drive({I,I,N,N}, 4'hF, 12'h900, 1'b1, 2'b00, 32'h0);
        #1;
`ifdef EHL_AHB_MATRIX_OUT_RR_EN
        exp_a = 32'h0001_0900;
`else
        exp_a = 32'h0000_0900;
`endif
        chk("arb_second", 103, os_haddr, exp_a);
        @(posedge hclk); #1;
        drive({I,I,I,I}, 4'hF, 12'h000, 1'b1, 2'b00, 32'h0);
        #1;
`ifdef EHL_AHB_MATRIX_OUT_RR_EN
        exp_a = 32'h0000_0900;
`else
        exp_a = 32'h0001_0900;
`endif
        chk("arb_loser_hsel",  104, 32'(os_hsel),   32'h1);
        chk("arb_loser_htrans",104, 32'(os_htrans), 32'(N));
        chk("arb_loser_haddr", 104, os_haddr,       exp_a);
        @(posedge hclk); #1;
        chk("arb_drain_hsel",  105, 32'(os_hsel),   32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
